// File: rtl/move_controller.sv
// Connect4 move sequencer: column heights, board writes, detector handshake, turn/game state.
// Optional CHECK watchdog compiled in with `define MOVE_CTRL_TIMEOUT_EN.
module move_controller #(
    parameter int COLS          = 4,
    parameter int ROWS          = 4,
    parameter int CHECK_TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    new_game,
    input  logic                    drop_req,
    input  logic [$clog2(COLS):0]   col_sel,
    input  logic                    win_done,
    input  logic [1:0]              win_result,
    output logic [ROWS*COLS-1:0]    board_occ,
    output logic [ROWS*COLS-1:0]    board_p2,
    output logic                    cur_player,
    output logic                    check_start,
    output logic                    move_accepted,
    output logic                    move_rejected,
    output logic [1:0]              game_status,
    output logic [1:0]              state,
    output logic                    timeout_flag
);

    localparam int CELLS  = ROWS * COLS;
    localparam int CIW    = $clog2(COLS);
    localparam int HW     = $clog2(ROWS + 1);
    localparam int MW     = $clog2(CELLS + 1);
    localparam int CELL_W = $clog2(CELLS);

    if (COLS < 2 || ROWS < 1 || CHECK_TIMEOUT < 1) begin : g_bad_params
        $error("move_controller: COLS >= 2, ROWS >= 1 and CHECK_TIMEOUT >= 1 required");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CHECK = 2'b01,
        OVER  = 2'b10
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [HW-1:0]     r_height [COLS];
    logic [HW-1:0]     w_height_nxt [COLS];
    logic [MW-1:0]     r_moves, w_moves_nxt;
    logic [CELLS-1:0]  r_occ, w_occ_nxt;
    logic [CELLS-1:0]  r_p2, w_p2_nxt;
    logic              r_cur, w_cur_nxt;
    logic [1:0]        r_status, w_status_nxt;
    logic              r_accepted, w_accepted_nxt;
    logic              r_rejected, w_rejected_nxt;
    logic              r_check_start, w_check_start_nxt;
    logic              r_timeout_flag, w_timeout_flag_nxt;

    logic [CIW-1:0]    w_col;
    logic              w_col_ok;
    logic              w_col_full;
    logic [CELL_W-1:0] w_cell;
    logic              w_timeout;
    logic [1:0]        w_result;

    assign w_col      = col_sel[CIW-1:0];
    assign w_col_ok   = int'(col_sel) < COLS;
    assign w_col_full = r_height[w_col] == HW'(ROWS);
    assign w_cell     = CELL_W'(int'(w_col) * ROWS + int'(r_height[w_col]));
    // A watchdog expiry resolves the check exactly like a "no winner" reply.
    assign w_result   = win_done ? win_result : 2'b00;

`ifdef MOVE_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(CHECK_TIMEOUT + 1);
    logic [TW-1:0] r_to_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_to_cnt <= '0;
        else if (r_state != CHECK || new_game)
            r_to_cnt <= '0;
        else
            r_to_cnt <= r_to_cnt + TW'(1);
    end

    assign w_timeout = (r_state == CHECK) && (r_to_cnt == TW'(CHECK_TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        // NOTE: every next-state value gets a default first so no path leaves one unassigned (no latches).
        w_state_nxt        = r_state;
        w_height_nxt       = r_height;
        w_moves_nxt        = r_moves;
        w_occ_nxt          = r_occ;
        w_p2_nxt           = r_p2;
        w_cur_nxt          = r_cur;
        w_status_nxt       = r_status;
        w_timeout_flag_nxt = r_timeout_flag;
        w_accepted_nxt     = 1'b0;
        w_rejected_nxt     = 1'b0;
        w_check_start_nxt  = 1'b0;

        if (new_game) begin
            w_state_nxt        = IDLE;
            for (int i = 0; i < COLS; i++) w_height_nxt[i] = '0;
            w_moves_nxt        = '0;
            w_occ_nxt          = '0;
            w_p2_nxt           = '0;
            w_cur_nxt          = 1'b0;
            w_status_nxt       = 2'b00;
            w_timeout_flag_nxt = 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (drop_req) begin
                        if (!w_col_ok || w_col_full) begin
                            w_rejected_nxt = 1'b1;
                        end else begin
                            w_occ_nxt[w_cell]   = 1'b1;
                            w_p2_nxt[w_cell]    = r_cur;
                            w_height_nxt[w_col] = r_height[w_col] + HW'(1);
                            w_moves_nxt         = r_moves + MW'(1);
                            w_accepted_nxt      = 1'b1;
                            w_check_start_nxt   = 1'b1;
                            w_state_nxt         = CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (win_done || w_timeout) begin
                        if (w_result == 2'b01 || w_result == 2'b10) begin
                            w_status_nxt = w_result;
                            w_state_nxt  = OVER;
                        end else if (r_moves == MW'(CELLS)) begin
                            w_status_nxt = 2'b11;
                            w_state_nxt  = OVER;
                        end else begin
                            w_cur_nxt    = ~r_cur;
                            w_state_nxt  = IDLE;
                        end
                        if (w_timeout && !win_done) w_timeout_flag_nxt = 1'b1;
                    end
                end
                OVER:    w_state_nxt = OVER;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= IDLE;
            // NOTE: the height table is a handful of flops, not a RAM, so it resets with the rest.
            for (int i = 0; i < COLS; i++) r_height[i] <= '0;
            r_moves        <= '0;
            r_occ          <= '0;
            r_p2           <= '0;
            r_cur          <= 1'b0;
            r_status       <= 2'b00;
            r_accepted     <= 1'b0;
            r_rejected     <= 1'b0;
            r_check_start  <= 1'b0;
            r_timeout_flag <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples the pre-edge values.
            r_state        <= w_state_nxt;
            r_height       <= w_height_nxt;
            r_moves        <= w_moves_nxt;
            r_occ          <= w_occ_nxt;
            r_p2           <= w_p2_nxt;
            r_cur          <= w_cur_nxt;
            r_status       <= w_status_nxt;
            r_accepted     <= w_accepted_nxt;
            r_rejected     <= w_rejected_nxt;
            r_check_start  <= w_check_start_nxt;
            r_timeout_flag <= w_timeout_flag_nxt;
        end
    end

    assign board_occ     = r_occ;
    assign board_p2      = r_p2;
    assign cur_player    = r_cur;
    assign check_start   = r_check_start;
    assign move_accepted = r_accepted;
    assign move_rejected = r_rejected;
    assign game_status   = r_status;
    assign state         = r_state;
    assign timeout_flag  = r_timeout_flag;

endmodule
